// File: rtl/keypad_scanner_pkg.sv
// Shared calculator package: key-code constants and the 4x4 keypad map.
// The control FSM imports the same constants, so a code emitted here decodes there unchanged.
package keypad_scanner_pkg;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KEY_SUM = 4'hA;
  localparam key_code_t KEY_SUB = 4'hB;
  localparam key_code_t KEY_STO = 4'hC;
  localparam key_code_t KEY_LD  = 4'hD;
  localparam key_code_t KEY_ENT = 4'hE;
  localparam key_code_t KEY_NOP = 4'hF;

  // Row/column to key code, indexed {row, col}.
  function automatic key_code_t key_code(input logic [1:0] row, input logic [1:0] col);
    key_code_t code;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = KEY_SUM;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = KEY_SUB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = KEY_STO;
      4'hC: code = KEY_NOP;
      4'hD: code = 4'h0;
      4'hE: code = KEY_ENT;
      default: code = KEY_LD;
    endcase
    return code;
  endfunction

  // True when exactly one active-low row is asserted.
  function automatic logic single_low(input logic [3:0] pat);
    return $countones(~pat) == 1;
  endfunction

  // Index of the low row; only meaningful when single_low(pat) holds.
  function automatic logic [1:0] low_row(input logic [3:0] pat);
    logic [1:0] idx;
    case (pat)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: matrix drive/sense plus the key-code output toward the control FSM.
//   master: scanner side (senses row_in, drives col_out/tecla/ready/pressed)
//   slave : keypad + consumer side
interface keypad_scanner_if;
  import keypad_scanner_pkg::*;

  logic [3:0] row_in;   // active-low rows, asynchronous
  logic [3:0] col_out;  // active-low column drive, one-cold
  key_code_t  tecla;    // last accepted key code
  logic       ready;    // one-cycle strobe, tecla new
  logic       pressed;  // accepted and not yet debounced-released

  modport master (input row_in, output col_out, tecla, ready, pressed);
  modport slave  (output row_in, input col_out, tecla, ready, pressed);
endinterface

// File: rtl/keypad_scanner_sync2.sv
// sync2: two-flop synchroniser for asynchronous inputs, reset to all-ones (idle pulled-up level).
//   clk, reset : system clock, synchronous active-high reset
//   d_i        : asynchronous input
//   q_o        : synchronised output
module sync2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans the 4x4 keypad, debounces rows and emits one key code per press.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : keypad_scanner_if.master (row_in in; col_out, tecla, ready, pressed out)
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 8
) (
  input  logic clk,
  input  logic reset,
  keypad_scanner_if.master bus
);
  localparam int unsigned DcntW = $clog2(SCAN_DIV);
  localparam int unsigned CntW  = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DcntW-1:0] DcntLast = DcntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]  CntDone  = CntW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {StScan, StDebounce, StEmit, StHold} state_e;

  state_e           state_q, state_d;
  logic [DcntW-1:0] dcnt_q, dcnt_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       cap_q, cap_d;
  logic [CntW-1:0]  match_q, match_d;
  logic [CntW-1:0]  rel_q, rel_d;
  key_code_t        tecla_q, tecla_d;
  logic             ready_q, ready_d;
  logic             pressed_q, pressed_d;
  logic [3:0]       rs;
  logic             sample;

  sync2 #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.row_in),
    .q_o   (rs)
  );

  // Dwell counter free-runs; rows are sampled on its last count.
  assign sample = (dcnt_q == DcntLast);
  assign dcnt_d = sample ? '0 : dcnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StScan;
      dcnt_q    <= '0;
      col_q     <= '0;
      cap_q     <= 4'hF;
      match_q   <= '0;
      rel_q     <= '0;
      tecla_q   <= KEY_NOP;
      ready_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      col_q     <= col_d;
      cap_q     <= cap_d;
      match_q   <= match_d;
      rel_q     <= rel_d;
      tecla_q   <= tecla_d;
      ready_q   <= ready_d;
      pressed_q <= pressed_d;
    end
  end

  // Counters are checked at the sample after they reach DEBOUNCE_CNT, so exactly
  // DEBOUNCE_CNT identical samples are needed and the count never exceeds its terminal value.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StScan:     if (sample && rs != 4'hF) state_d = StDebounce;
      StDebounce: begin
        if (sample) begin
          if (match_q == CntDone) state_d = StEmit;
          else if (rs != cap_q)   state_d = StScan;
        end
      end
      StEmit:     state_d = StHold;
      StHold:     if (sample && rel_q == CntDone) state_d = StScan;
    endcase
  end

  always_comb begin
    col_d     = col_q;
    cap_d     = cap_q;
    match_d   = match_q;
    rel_d     = rel_q;
    tecla_d   = tecla_q;
    ready_d   = 1'b0;
    pressed_d = pressed_q;
    unique case (state_q)
      StScan: begin
        if (sample) begin
          if (rs == 4'hF) begin
            col_d = col_q + 2'd1;
          end else begin
            cap_d   = rs;
            match_d = CntW'(1);
          end
        end
      end
      StDebounce: begin
        if (sample && match_q != CntDone) begin
          if (rs == cap_q) begin
            match_d = match_q + 1'b1;
          end else begin
            match_d = '0;
            col_d   = col_q + 2'd1;
          end
        end
      end
      StEmit: begin
        match_d = '0;
        rel_d   = '0;
        // Multi-row patterns are ambiguous and dropped, but still wait for release.
        if (single_low(cap_q)) begin
          tecla_d   = key_code(low_row(cap_q), col_q);
          ready_d   = 1'b1;
          pressed_d = 1'b1;
        end else begin
          pressed_d = 1'b0;
        end
      end
      StHold: begin
        if (sample) begin
          if (rel_q == CntDone) begin
            pressed_d = 1'b0;
            rel_d     = '0;
            col_d     = col_q + 2'd1;
          end else if (rs == 4'hF) begin
            rel_d = rel_q + 1'b1;
          end else begin
            rel_d = '0;
          end
        end
      end
    endcase
  end

  assign bus.col_out = ~(4'b0001 << col_q);
  assign bus.tecla   = tecla_q;
  assign bus.ready   = ready_q;
  assign bus.pressed = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3 and a keypad matrix model.
module tb_keypad_scanner;
  localparam int unsigned SD = 4;
  localparam int unsigned DB = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if bus ();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // keys[r][c] = 1 while that key is held.
  logic [3:0] keys [4];

  always_comb begin
    logic [3:0] rows;
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r][c] && !bus.col_out[c]) rows[r] = 1'b0;
    bus.row_in = rows;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ready_cnt = 0, dbl_cnt = 0, pressed_cnt = 0;
  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    if (bus.ready === 1'b1) begin
      ready_cnt++;
      if (prev_ready) dbl_cnt++;
    end
    prev_ready = bus.ready;
    if (bus.pressed === 1'b1) pressed_cnt++;
  end

  int errors = 0, checks = 0;

  task automatic chk4(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chki(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_ready(input int target, input int budget, input string tag);
    int i = 0;
    while (ready_cnt < target && i < budget) begin
      tick();
      i++;
    end
    chk1(tag, ready_cnt >= target, 1'b1);
  endtask

  task automatic wait_release(input int budget, input string tag);
    int i = 0;
    while (bus.pressed === 1'b1 && i < budget) begin
      tick();
      i++;
    end
    chk1(tag, bus.pressed, 1'b0);
  endtask

  int base, r0, p0, ks, chg, k;
  logic [3:0] exp_col, prev_col;

  initial begin
    for (int r = 0; r < 4; r++) keys[r] = 4'h0;
    reset = 1'b1;
    ticks(3);
    reset = 1'b0;
    base = cyc;

    // Reset state, then idle rotation E,D,B,7 every 4 cycles.
    chk4("rst_col", bus.col_out, 4'hE);
    chk4("rst_tecla", bus.tecla, 4'hF);
    chk1("rst_ready", bus.ready, 1'b0);
    chk1("rst_pressed", bus.pressed, 1'b0);
    for (int i = 0; i < 200; i++) begin
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      chk4("idle_col", bus.col_out, exp_col);
      tick();
    end
    chki("idle_ready_cnt", ready_cnt, 0);
    chk4("idle_tecla", bus.tecla, 4'hF);

    // Stable "5" (r1c1), then release timing.
    r0 = ready_cnt;
    keys[1][1] = 1'b1;
    wait_ready(r0 + 1, 100, "k5_timeout");
    chk4("k5_tecla", bus.tecla, 4'h5);
    chk1("k5_pressed", bus.pressed, 1'b1);
    ticks(40);
    chki("k5_single", ready_cnt, r0 + 1);
    keys[1][1] = 1'b0;
    ks = (cyc - base) + 2;
    while (ks % 4 != 3) ks++;
    while ((cyc - base) < ks + 12) tick();
    chk1("k5_pressed_hold", bus.pressed, 1'b1);
    tick();
    chk1("k5_pressed_fall", bus.pressed, 1'b0);

    // Bouncing "1" (r0c0) settling to a stable press.
    r0 = ready_cnt;
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) keys[0][0] = ~keys[0][0];
      tick();
    end
    keys[0][0] = 1'b1;
    wait_ready(r0 + 1, 200, "k1_timeout");
    chk4("k1_tecla", bus.tecla, 4'h1);
    ticks(30);
    chki("k1_single", ready_cnt, r0 + 1);
    keys[0][0] = 1'b0;
    wait_release(100, "k1_release");

    // Two rows in column 2: discarded, scanning resumes after release.
    r0 = ready_cnt;
    p0 = pressed_cnt;
    keys[0][2] = 1'b1;
    keys[2][2] = 1'b1;
    ticks(100);
    chki("multi_no_ready", ready_cnt, r0);
    chki("multi_no_pressed", pressed_cnt, p0);
    chk4("multi_col_frozen", bus.col_out, 4'hB);
    keys[0][2] = 1'b0;
    keys[2][2] = 1'b0;
    ticks(30);
    chg = 0;
    prev_col = bus.col_out;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (bus.col_out !== prev_col) chg++;
      prev_col = bus.col_out;
    end
    chki("multi_scan_resume", chg, 8);

    // "2" then "E"; long hold of E gives no extra strobe.
    r0 = ready_cnt;
    keys[0][1] = 1'b1;
    wait_ready(r0 + 1, 100, "k2_timeout");
    chk4("k2_tecla", bus.tecla, 4'h2);
    ticks(10);
    keys[0][1] = 1'b0;
    wait_release(100, "k2_release");
    ticks(5);
    keys[3][2] = 1'b1;
    wait_ready(r0 + 2, 100, "kE_timeout");
    chk4("kE_tecla", bus.tecla, 4'hE);
    ticks(500);
    chki("kE_no_repeat", ready_cnt, r0 + 2);
    chk1("kE_pressed", bus.pressed, 1'b1);
    keys[3][2] = 1'b0;
    wait_release(100, "kE_release");

    // Reset while "9" (r2c2) is being debounced.
    keys[2][2] = 1'b1;
    k = 0;
    while (bus.col_out === 4'hB && k < 20) begin tick(); k++; end
    k = 0;
    while (bus.col_out !== 4'hB && k < 20) begin tick(); k++; end
    chk4("k9_col_reached", bus.col_out, 4'hB);
    ticks(5);
    chk4("k9_col_frozen", bus.col_out, 4'hB);
    chk1("k9_no_ready_yet", bus.ready, 1'b0);
    chk4("k9_tecla_before", bus.tecla, 4'hE);
    reset = 1'b1;
    keys[2][2] = 1'b0;
    tick();
    chk4("mid_rst_col", bus.col_out, 4'hE);
    chk4("mid_rst_tecla", bus.tecla, 4'hF);
    chk1("mid_rst_ready", bus.ready, 1'b0);
    chk1("mid_rst_pressed", bus.pressed, 1'b0);
    reset = 1'b0;
    base = cyc;
    r0 = ready_cnt;
    ticks(200);
    chki("post_rst_no_ready", ready_cnt, r0);
    chk4("post_rst_tecla", bus.tecla, 4'hF);
    chki("no_back_to_back_ready", dbl_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
